// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator: byte enables, size op, load extension, ack timeout.
// Define MISALIGN_EXC_EN to error-complete misaligned word/half accesses without touching memory.
module lsu_mem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_op,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_op_q, mem_op_d, lane_q, lane_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        sign_q, sign_d;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic [1:0]  op_n;
  logic        misalign;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // Lane select uses the full offset for bytes and only a[1] for halves.
  always_comb begin
    shifted  = mem_rdata >> {lane_q, 3'b000};
    load_ext = mem_rdata;
    if (mem_op_q == 2'd2) begin
      load_ext = {{24{sign_q & shifted[7]}}, shifted[7:0]};
    end else if (mem_op_q == 2'd1) begin
      load_ext = lane_q[1] ? {{16{sign_q & mem_rdata[31]}}, mem_rdata[31:16]}
                           : {{16{sign_q & mem_rdata[15]}}, mem_rdata[15:0]};
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_op_d     = mem_op_q;
    mem_be_d     = mem_be_q;
    lane_d       = lane_q;
    sign_d       = sign_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    op_n         = (req_size == 2'd3) ? 2'd0 : req_size;
    misalign     = 1'b0;
`ifdef MISALIGN_EXC_EN
    misalign = ((op_n == 2'd0) && (req_addr[1:0] != 2'd0)) ||
               ((op_n == 2'd1) && req_addr[0]);
`else
    misalign = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_wdata_d = req_wdata;
          mem_op_d    = op_n;
          lane_d      = req_addr[1:0];
          sign_d      = req_sign;
          case (op_n)
            2'd1:    mem_be_d = req_addr[1] ? 4'b1100 : 4'b0011;
            2'd2:    mem_be_d = 4'b0001 << req_addr[1:0];
            default: mem_be_d = 4'b1111;
          endcase
          if (misalign) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d   = BUSY;
            mem_req_d = 1'b1;
            cnt_d     = 16'd0;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = mem_we_q ? 32'd0 : load_ext;
        end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_op_q     <= 2'd0;
      mem_be_q     <= 4'd0;
      lane_q       <= 2'd0;
      sign_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_op_q     <= mem_op_d;
      mem_be_q     <= mem_be_d;
      lane_q       <= lane_d;
      sign_q       <= sign_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = reset & (state_q == IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_op     = mem_op_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign stall      = (req_valid & ~resp_valid_q) | (state_q == BUSY);

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed-vector bench for lsu_mem_master (TIMEOUT_CYCLES=4).
module tb_lsu_mem_master;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, mem_req, mem_we, resp_valid, resp_err, stall;
  logic [31:0] mem_addr, mem_wdata, resp_rdata;
  logic [1:0]  mem_op;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  int          n_cmp = 0;
  int          n_bad = 0;

  lsu_mem_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_op(mem_op),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [1:0] exp_op,
                        input logic [31:0] exp_rdata);
    issue(we, size, sign, addr, wdata);
    chk({tag, "_mem_req"}, mem_req, 1);
    chk({tag, "_stall"}, stall, 1);
    chk({tag, "_mem_addr"}, mem_addr, exp_addr);
    chk({tag, "_mem_be"}, mem_be, exp_be);
    chk({tag, "_mem_op"}, mem_op, exp_op);
    chk({tag, "_mem_we"}, mem_we, we);
    chk({tag, "_mem_wdata"}, mem_wdata, wdata);
    mem_ack = 1'b1; mem_rdata = rdata;
    cyc();
    mem_ack = 1'b0;
    chk({tag, "_resp_valid"}, resp_valid, 1);
    chk({tag, "_resp_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_mem_req_off"}, mem_req, 0);
    cyc();
    chk({tag, "_resp_pulse_end"}, resp_valid, 0);
    chk({tag, "_ready_again"}, req_ready, 1);
  endtask

  initial begin
    int busy;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_be", mem_be, 0);
    reset = 1'b1;
    cyc();
    chk("idle_req_ready", req_ready, 1);

    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    cyc();
    mem_ack = 1'b0;
    chk("idle_ack_ignored", resp_valid, 0);

    access("lw", 1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'h8765_4321, 32'h10, 4'b1111, 2'd0, 32'h8765_4321);
    access("lb", 1'b0, 2'd2, 1'b1, 32'h13, 32'h0, 32'h8012_3456, 32'h10, 4'b1000, 2'd2, 32'hFFFF_FF80);
    access("lbu", 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h8012_3456, 32'h10, 4'b1000, 2'd2, 32'h0000_0080);
    access("lb1", 1'b0, 2'd2, 1'b1, 32'h21, 32'h0, 32'h0000_7F00, 32'h20, 4'b0010, 2'd2, 32'h0000_007F);
    access("lh0", 1'b0, 2'd1, 1'b1, 32'h40, 32'h0, 32'h1234_9ABC, 32'h40, 4'b0011, 2'd1, 32'hFFFF_9ABC);
    access("sh", 1'b1, 2'd1, 1'b0, 32'h06, 32'h0000_BEEF, 32'hFFFF_FFFF, 32'h04, 4'b1100, 2'd1, 32'h0);
    access("sz3", 1'b0, 2'd3, 1'b0, 32'h08, 32'h0, 32'hCAFE_F00D, 32'h08, 4'b1111, 2'd0, 32'hCAFE_F00D);

    issue(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
    busy = 0;
    for (int i = 0; i < 20 && !resp_valid; i++) begin
      if (mem_req) busy++;
      cyc();
    end
    chk("to_busy_cycles", busy, 4);
    chk("to_resp_valid", resp_valid, 1);
    chk("to_resp_err", resp_err, 1);
    chk("to_resp_rdata", resp_rdata, 0);
    chk("to_mem_req_low", mem_req, 0);
    cyc();
    chk("to_pulse_end", resp_valid, 0);

    issue(1'b0, 2'd0, 1'b0, 32'h30, 32'h0);
    chk("rm_busy", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("rm_mem_req_drop", mem_req, 0);
    @(negedge clk);
    reset = 1'b1;
    busy = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) busy++;
      cyc();
    end
    chk("rm_no_resp", busy, 0);
    access("lhu", 1'b0, 2'd1, 1'b0, 32'h02, 32'h0, 32'h1234_5678, 32'h00, 4'b1100, 2'd1, 32'h0000_1234);

`ifdef MISALIGN_EXC_EN
    issue(1'b0, 2'd0, 1'b0, 32'h01, 32'h0);
    chk("mis_no_mem_req", mem_req, 0);
    chk("mis_resp_valid", resp_valid, 1);
    chk("mis_resp_err", resp_err, 1);
    chk("mis_resp_rdata", resp_rdata, 0);
    cyc();
    chk("mis_pulse_end", resp_valid, 0);
`else
    access("mis", 1'b0, 2'd0, 1'b0, 32'h01, 32'h0, 32'h0BAD_F00D, 32'h00, 4'b1111, 2'd0, 32'h0BAD_F00D);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
